// File: rtl/pci_arbiter.sv
// Four-device PCI bus arbiter: round-robin grant, FRAME-based bus capture,
// unresponsive-grant timeout and a single turnaround cycle after each transfer.
module pci_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] REQ,
   input  logic       FRAME,
   input  logic       IRDY,
   output logic [3:0] GNT,
   output logic [1:0] OWNER,
   output logic       BUS_BUSY
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] owner_q, owner_d;   // also serves as the registered winner
   logic [1:0] last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic [1:0] rr_pick;
   logic [1:0] rr_idx;

   // Walk offsets from farthest to nearest so the device right after last_q wins.
   always_comb begin
      rr_pick = 2'd0;
      rr_idx  = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         rr_idx = last_q + 2'(k);
         if (!REQ[rr_idx]) rr_pick = rr_idx;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = 4'hF;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (REQ != 4'hF) begin
               gnt_d   = ~(4'b0001 << rr_pick);
               owner_d = rr_pick;
               cnt_d   = 8'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            gnt_d = gnt_q;
            if (!FRAME) begin
               gnt_d   = 4'hF;
               last_d  = owner_q;
               state_d = BUSY;
            end else if (REQ[owner_q]) begin
               gnt_d   = 4'hF;
               state_d = IDLE;
            end else if (cnt_q == TO_LAST) begin
               gnt_d   = 4'hF;
               last_d  = owner_q;
               state_d = IDLE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         BUSY: begin
            if (FRAME && IRDY) state_d = TURN;
         end
         TURN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == BUSY) || (state_d == TURN);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= 4'hF;
         owner_q <= 2'd0;
         last_q  <= 2'd3;
         cnt_q   <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // At most one grant low, and no grant at all while the bus is owned or turning.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert ($onehot0(~gnt_q));
         assert (!((state_q == BUSY) || (state_q == TURN)) || (gnt_q == 4'hF));
      end
   end

   assign GNT      = gnt_q;
   assign OWNER    = owner_q;
   assign BUS_BUSY = busy_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Bench for pci_arbiter: a rule-level reference model feeds an expected queue that
// a negedge monitor drains, plus directed scenarios for grant order, timeout and reset.
module tb_pci_arbiter;

   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'hF;
   logic       frame_n = 1'b1;
   logic       irdy_n = 1'b1;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       bus_busy;

   int n_checks = 0;
   int n_pass = 0;

   logic [6:0] exp_q[$];

   pci_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .CLK(clk), .RST(rst), .REQ(req), .FRAME(frame_n), .IRDY(irdy_n),
      .GNT(gnt), .OWNER(owner), .BUS_BUSY(bus_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: phase 0=bus free, 1=device granted, 2=transfer, 3=turnaround.
   int         m_phase = 0;
   int         m_win = 0;
   int         m_last = 3;
   int         m_cnt = 0;
   logic [3:0] m_gnt = 4'hF;
   logic [1:0] m_owner = 2'd0;
   logic       m_busy = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_last = 3; m_cnt = 0;
         m_gnt = 4'hF; m_owner = 2'd0; m_busy = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               if (req != 4'hF) begin
                  bit found;
                  found = 0;
                  for (int k = 1; k <= 4; k++) begin
                     if (!found && !req[(m_last + k) % 4]) begin
                        m_win = (m_last + k) % 4;
                        found = 1;
                     end
                  end
                  m_gnt = 4'hF;
                  m_gnt[m_win] = 1'b0;
                  m_owner = 2'(m_win);
                  m_cnt = 0;
                  m_phase = 1;
               end
            end
            1: begin
               if (!frame_n) begin
                  m_gnt = 4'hF; m_last = m_win; m_phase = 2; m_busy = 1'b1;
               end else if (req[m_win]) begin
                  m_gnt = 4'hF; m_phase = 0;
               end else if (m_cnt == TIMEOUT - 1) begin
                  m_gnt = 4'hF; m_last = m_win; m_phase = 0;
               end else begin
                  m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
               end
            end
            2: if (frame_n && irdy_n) m_phase = 3;
            default: begin
               m_phase = 0; m_busy = 1'b0;
            end
         endcase
      end
      exp_q.push_back({m_gnt, m_owner, m_busy});
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [6:0] e;
         e = exp_q.pop_front();
         check("model_out", {25'd0, gnt, owner, bus_busy}, {25'd0, e});
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 4'hF; frame_n = 1'b1; irdy_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int low_index(input logic [3:0] g);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (!g[i]) r = i;
      return r;
   endfunction

   initial begin
      int order[5];
      int low;
      bit found;

      do_reset();
      check("reset_out", {25'd0, gnt, owner, bus_busy}, {25'd0, 4'hF, 2'd0, 1'b0});

      // Single request followed by a three-cycle transfer.
      req = 4'b1101;
      @(negedge clk);
      check("single_grant", {26'd0, gnt, owner}, {26'd0, 4'b1101, 2'd1});
      frame_n = 1'b0; req = 4'hF;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("single_busy", {27'd0, gnt, bus_busy}, {27'd0, 4'hF, 1'b1});
      end
      frame_n = 1'b1;
      @(negedge clk);
      check("single_turn", {27'd0, gnt, bus_busy}, {27'd0, 4'hF, 1'b1});
      @(negedge clk);
      check("single_idle", {27'd0, gnt, bus_busy}, {27'd0, 4'hF, 1'b0});

      // Round-robin with everybody requesting.
      do_reset();
      req = 4'b0000;
      for (int g = 0; g < 5; g++) begin
         found = 0;
         order[g] = -1;
         for (int w = 0; w < 10 && !found; w++) begin
            @(negedge clk);
            if (gnt != 4'hF) begin
               found = 1;
               order[g] = low_index(gnt);
            end
         end
         check("rr_grant_seen", 32'(found), 32'd1);
         frame_n = 1'b0;
         @(negedge clk);
         @(negedge clk);
         frame_n = 1'b1;
      end
      check("rr_order0", 32'(order[0]), 32'd0);
      check("rr_order1", 32'(order[1]), 32'd1);
      check("rr_order2", 32'(order[2]), 32'd2);
      check("rr_order3", 32'(order[3]), 32'd3);
      check("rr_order4", 32'(order[4]), 32'd0);

      // Unresponsive device 0 times out; device 1 then wins.
      do_reset();
      req = 4'b1110;
      found = 0;
      for (int w = 0; w < 4 && !found; w++) begin
         @(negedge clk);
         if (!gnt[0]) found = 1;
      end
      check("to_grant_seen", 32'(found), 32'd1);
      low = 1;
      while (low < 40) begin
         @(negedge clk);
         if (gnt[0]) break;
         low++;
      end
      check("to_length", 32'(low), 32'(TIMEOUT));
      req = 4'b1100;
      @(negedge clk);
      check("to_next_owner", {26'd0, gnt, owner}, {26'd0, 4'b1101, 2'd1});

      // Withdrawn request keeps the priority pointer where it was.
      do_reset();
      req = 4'b1011;
      @(negedge clk);
      check("wd_grant", {26'd0, gnt, owner}, {26'd0, 4'b1011, 2'd2});
      req = 4'hF;
      @(negedge clk);
      check("wd_release", {28'd0, gnt}, {28'd0, 4'hF});
      req = 4'b0000;
      @(negedge clk);
      check("wd_next", {28'd0, gnt}, {28'd0, 4'b1110});

      // Reset in the middle of a transfer.
      do_reset();
      req = 4'b1011;
      @(negedge clk);
      frame_n = 1'b0; req = 4'hF;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_busy", {31'd0, bus_busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out", {25'd0, gnt, owner, bus_busy}, {25'd0, 4'hF, 2'd0, 1'b0});
      rst = 1'b0; frame_n = 1'b1; req = 4'b0000;
      @(negedge clk);
      check("rst_mid_first", {28'd0, gnt}, {28'd0, 4'b1110});

      // Randomised segments: held request patterns with jitter, mixed bus activity.
      do_reset();
      for (int s = 0; s < 90; s++) begin
         logic [3:0] base;
         int len;
         bit quiet_bus;
         base = 4'($urandom_range(0, 15));
         len = $urandom_range(5, 30);
         quiet_bus = ($urandom_range(0, 2) == 0);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            req = base ^ (($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
            frame_n = quiet_bus ? 1'b1 : ($urandom_range(0, 9) > 2);
            irdy_n = 1'($urandom_range(0, 1));
         end
      end
      rst = 1'b0; req = 4'hF; frame_n = 1'b1; irdy_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, sets the number of cycles a granted device has to assert FRAME before its grant is withdrawn (range 2..255).
REQ-002 Port: CLK  input  1  bus clock; all state changes on the rising edge.
REQ-003 Port: RST  input  1  synchronous reset, active-high.
REQ-004 Port: REQ  input  4  bus requests, active-low, one bit per device address 0..3.
REQ-005 Port: FRAME  input  1  bus FRAME, active-low, sampled only.
REQ-006 Port: IRDY  input  1  bus IRDY, active-low, sampled only.
REQ-007 Port: GNT  output  4  bus grants, active-low, registered, at most one bit low.
REQ-008 Port: OWNER  output  2  index of the last device granted, registered.
REQ-009 Port: BUS_BUSY  output  1  high while state is BUSY or TURN, registered.

Function
REQ-010 The FSM SHALL have four states: IDLE, GRANT, BUSY and TURN; the winner, last-owner and timeout counter SHALL all be registered.
REQ-011 Bus idle SHALL be defined as FRAME==1 && IRDY==1, sampled at the rising edge.
REQ-012 IDLE: GNT=4'b1111; if any REQ bit is 0, the block SHALL select the winner by round-robin, searching from last_owner+1 (mod 4) upward, then drive GNT[winner]=0 and OWNER=winner on that same edge and enter GRANT.
REQ-013 Latency: GNT SHALL go low one edge after REQ is sampled low, i.e. visible in the cycle following the sampling edge.
REQ-014 GRANT: if REQ[winner] is sampled 1, the block SHALL drive GNT=4'b1111 and return to IDLE, and last_owner SHALL NOT change.
REQ-015 GRANT: if FRAME is sampled 0, the block SHALL drive GNT=4'b1111, set last_owner=winner and enter BUSY.
REQ-016 GRANT: the timeout counter SHALL increment each cycle; when it reaches TIMEOUT-1 with FRAME still 1, the block SHALL drive GNT=4'b1111, set last_owner=winner (the unresponsive device loses priority) and enter IDLE.
REQ-017 The timeout counter SHALL clear on every entry to GRANT and be 8 bits wide, saturating.
REQ-018 If REQ[winner] deasserts and FRAME asserts on the same edge, the FRAME rule (REQ-015) SHALL take precedence.
REQ-019 BUSY: GNT SHALL remain 4'b1111, and REQ changes SHALL be ignored; when the bus is sampled idle, the block SHALL enter TURN.
REQ-020 TURN: the block SHALL spend exactly one cycle with GNT=4'b1111, then go to IDLE; pending requests are arbitrated in IDLE on the next edge.
REQ-021 The 2-bit round-robin pointer SHALL wrap 3→0.
REQ-022 A device requesting continuously SHALL NOT be granted twice in a row while another device is requesting.
REQ-023 GNT SHALL never have more than one bit at 0, in any state or cycle.

Reset
REQ-024 RST=1 at a rising edge SHALL force: state=IDLE, GNT=4'b1111, OWNER=2'd0, BUS_BUSY=0, last_owner=2'd3 (device 0 wins first), counter=0.
REQ-025 Reset asserted during GRANT or BUSY SHALL remove the grant at that edge, with no TURN cycle.
REQ-026 RST SHALL take priority over all other inputs.

Verification
REQ-027 Single request: after reset, REQ=4'b1101 → GNT=4'b1101 and OWNER=1 one edge later; FRAME=0 for 3 cycles then FRAME=IRDY=1 → BUS_BUSY=1 through BUSY plus one TURN cycle, GNT=4'b1111 throughout.
REQ-028 Round-robin: REQ=4'b0000 held, each grantee runs a 2-cycle FRAME → grant order 0,1,2,3,0.
REQ-029 Timeout: TIMEOUT=16, REQ=4'b1110, FRAME held 1 → GNT[0] low for exactly 16 cycles, then 4'b1111; with REQ=4'b1100 the next grant goes to device 1.
REQ-030 Withdrawn request: grant to device 2, then REQ[2]→1 before FRAME → GNT=4'b1111 the next edge, state IDLE, next grant still searches from last_owner+1.
REQ-031 Reset mid-transfer: RST=1 in BUSY → GNT=4'b1111, BUS_BUSY=0, OWNER=0 on that edge; with REQ=4'b0000 afterwards, device 0 is granted first.
REQ-032 A continuous assertion SHALL check that GNT has at most one zero bit and is 4'b1111 in BUSY and TURN.
